// File: rtl/ref_timer_mc.sv
// ref_timer_mc: multi-channel refresh scheduler with per-channel REF debt and round-robin REF issue.
// Define REF_TIMER_MC_URGENT_EN to let channels at maximum debt win arbitration.
package rpc_config_path_pkg;
    typedef struct packed {
        logic        enable;
        logic        ref_refop;
        logic [3:0]  ref_bank_list;
        logic [15:0] interval;
    } ref_cfg_reg_t;
    localparam ref_cfg_reg_t REF_TIMER_DEFAULT_SETTING =
        '{enable: 1'b0, ref_refop: 1'b0, ref_bank_list: 4'h0, interval: 16'd60};
endpackage

module ref_timer_mc
    import rpc_config_path_pkg::*;
#(
    parameter int NUM_CH         = 4,
    parameter int CNT_WIDTH      = 32,
    parameter int CMD_WIDTH      = 19,
    parameter int INTERVAL_SHIFT = 7,
    parameter int MAX_DEBT       = 8,
    localparam int CH_W          = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 init_timer_i,
    input  logic                 load_config_i,
    input  logic [CH_W-1:0]      load_ch_i,
    input  ref_cfg_reg_t         config_i,
    input  logic                 ref_ready_i,
    output logic                 ref_valid_o,
    output logic [CMD_WIDTH-1:0] ref_cmd_o,
    output logic [CH_W-1:0]      ref_ch_o,
    output logic                 ref_urgent_o,
    output logic [NUM_CH-1:0]    debt_ovf_o
);
    localparam int DW = $clog2(MAX_DEBT + 1);
    localparam logic [DW-1:0] MAX_D = DW'(MAX_DEBT);

    typedef enum logic [1:0] {POWER_UP, INIT, IDLE, COUNTING} state_t;

    state_t               state   [NUM_CH];
    ref_cfg_reg_t         cfg     [NUM_CH];
    ref_cfg_reg_t         buf_cfg [NUM_CH];
    logic                 buf_vld [NUM_CH];
    logic [CNT_WIDTH-1:0] cnt     [NUM_CH];
    logic [DW-1:0]        debt    [NUM_CH];
    logic [NUM_CH-1:0]    tick, consume, load_hit, dec, req, at_max;
    logic [CH_W-1:0]      rr_ptr, pick, rr_pick, lo_pick;
    logic                 rr_found, any_req, pick_urgent, hs, refop_unused;

    assign hs = ref_valid_o && ref_ready_i;

    always_comb begin
        refop_unused = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            tick[i]     = state[i] == COUNTING &&
                          cnt[i] == (CNT_WIDTH'(cfg[i].interval) << INTERVAL_SHIFT) - CNT_WIDTH'(1);
            load_hit[i] = load_config_i && load_ch_i == CH_W'(i);
            consume[i]  = buf_vld[i] && (state[i] == INIT || (state[i] == IDLE && !cfg[i].enable) || tick[i]);
            dec[i]      = hs && ref_ch_o == CH_W'(i);
            req[i]      = debt[i] != '0;
            at_max[i]   = debt[i] == MAX_D;
            refop_unused ^= cfg[i].ref_refop;
        end
    end

    // Descending scan: the lowest requester at/after the pointer wins, else the lowest overall (wrap).
    always_comb begin
        rr_found = 1'b0;
        any_req  = 1'b0;
        rr_pick  = '0;
        lo_pick  = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (req[i]) begin
                any_req = 1'b1;
                lo_pick = CH_W'(i);
            end
            if (req[i] && CH_W'(i) >= rr_ptr) begin
                rr_found = 1'b1;
                rr_pick  = CH_W'(i);
            end
        end
    end

`ifdef REF_TIMER_MC_URGENT_EN
    logic            urg_any;
    logic [CH_W-1:0] urg_pick;
    always_comb begin
        urg_any  = 1'b0;
        urg_pick = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (at_max[i]) begin
                urg_any  = 1'b1;
                urg_pick = CH_W'(i);
            end
        end
    end
    assign pick_urgent = urg_any;
    assign pick        = urg_any ? urg_pick : rr_found ? rr_pick : lo_pick;
`else
    assign pick_urgent = 1'b0;
    assign pick        = rr_found ? rr_pick : lo_pick;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            debt_ovf_o <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                state[i]   <= POWER_UP;
                cfg[i]     <= '0;
                buf_cfg[i] <= '0;
                buf_vld[i] <= 1'b0;
                cnt[i]     <= '0;
                debt[i]    <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                buf_vld[i] <= load_hit[i] || (buf_vld[i] && !consume[i]);
                if (load_hit[i]) buf_cfg[i] <= config_i;
                if (consume[i]) cfg[i] <= buf_cfg[i];
                else if (state[i] == INIT) cfg[i] <= REF_TIMER_DEFAULT_SETTING;
                cnt[i] <= (state[i] == COUNTING && !tick[i]) ? cnt[i] + CNT_WIDTH'(1) : '0;
                case (state[i])
                    POWER_UP: if (init_timer_i) state[i] <= INIT;
                    INIT:     state[i] <= IDLE;
                    IDLE:     if (cfg[i].enable) state[i] <= COUNTING;
                    default:  if (consume[i] && !buf_cfg[i].enable) state[i] <= IDLE;
                endcase
                // A tick cancelled by a same-cycle grant is neither counted nor lost.
                if (tick[i] && !dec[i] && at_max[i]) debt_ovf_o[i] <= 1'b1;
                if (tick[i] && !dec[i] && !at_max[i]) debt[i] <= debt[i] + DW'(1);
                else if (dec[i] && !tick[i]) debt[i] <= debt[i] - DW'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ref_valid_o  <= 1'b0;
            ref_cmd_o    <= '0;
            ref_ch_o     <= '0;
            ref_urgent_o <= 1'b0;
            rr_ptr       <= '0;
        end else if (ref_valid_o) begin
            if (ref_ready_i) begin
                ref_valid_o <= 1'b0;
                rr_ptr      <= (ref_ch_o == CH_W'(NUM_CH - 1)) ? '0 : ref_ch_o + CH_W'(1);
            end
        end else if (any_req) begin
            ref_valid_o  <= 1'b1;
            ref_ch_o     <= pick;
            ref_urgent_o <= pick_urgent;
            ref_cmd_o    <= CMD_WIDTH'({2'b00, cfg[pick].ref_bank_list, 13'b0});
        end
    end

    // A zero interval makes ceiling-1 all-ones, so an enabled channel would silently never tick.
    for (genvar g = 0; g < NUM_CH; g++) begin : g_chk
        assert property (@(posedge clk_i) disable iff (!rst_ni)
            !(state[g] == COUNTING && cfg[g].interval == '0));
    end
endmodule

// File: tb/tb_ref_timer_mc.sv
// tb_ref_timer_mc: directed scenario bench for ref_timer_mc (NUM_CH=2, MAX_DEBT=8, INTERVAL_SHIFT=7).
module tb_ref_timer_mc;
    import rpc_config_path_pkg::*;

`ifdef REF_TIMER_MC_URGENT_EN
    localparam logic EXP_URG = 1'b1;
`else
    localparam logic EXP_URG = 1'b0;
`endif

    logic         clk = 1'b0, rst_n = 1'b0, init_timer = 1'b0, load_config = 1'b0, ref_ready = 1'b0;
    logic [0:0]   load_ch = 1'b0;
    ref_cfg_reg_t cfg_in = '0;
    logic         ref_valid, ref_urgent;
    logic [18:0]  ref_cmd;
    logic [0:0]   ref_ch;
    logic [1:0]   debt_ovf;
    int           errors = 0, checks = 0, e = 0;

    always #5 clk = ~clk;

    ref_timer_mc #(.NUM_CH(2)) dut (
        .clk_i(clk), .rst_ni(rst_n), .init_timer_i(init_timer), .load_config_i(load_config),
        .load_ch_i(load_ch), .config_i(cfg_in), .ref_ready_i(ref_ready), .ref_valid_o(ref_valid),
        .ref_cmd_o(ref_cmd), .ref_ch_o(ref_ch), .ref_urgent_o(ref_urgent), .debt_ovf_o(debt_ovf)
    );

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            e++;
        end
    endtask

    task automatic step_to(input int t);
        while (e < t) step(1);
    endtask

    task automatic do_reset();
        rst_n = 1'b0; init_timer = 1'b0; load_config = 1'b0; ref_ready = 1'b0;
        step(2);
        rst_n = 1'b1;
        step(1);
    endtask

    task automatic load(input logic ch, input logic en, input logic [3:0] bank, input logic [15:0] iv);
        load_ch = ch;
        cfg_in = '{enable: en, ref_refop: 1'b0, ref_bank_list: bank, interval: iv};
        load_config = 1'b1;
        step(1);
        load_config = 1'b0;
    endtask

    // e counts edges after the edge that samples init_timer
    task automatic start();
        init_timer = 1'b1;
        step(1);
        init_timer = 1'b0;
        e = 0;
    endtask

    task automatic run_grants(input int n, output int cnt, output int gaps, output logic [7:0] seq,
                              output logic [18:0] cmd1);
        logic prev_hs;
        prev_hs = 1'b0; cnt = 0; gaps = 0; seq = '0; cmd1 = '0;
        repeat (n) begin
            if (prev_hs && ref_valid) gaps++;
            prev_hs = ref_valid && ref_ready;
            if (prev_hs) begin
                if (cnt < 8) seq[cnt] = ref_ch[0];
                if (ref_ch[0] && cmd1 == '0) cmd1 = ref_cmd;
                cnt++;
            end
            step(1);
        end
    endtask

    task automatic measure_latency(output int lat);
        lat = -1;
        while (e < 300 && lat < 0) begin
            if (ref_valid) lat = e;
            else step(1);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step(2);
        checks++; if (ref_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", ref_valid); end
        checks++; if (ref_cmd !== 19'h0) begin errors++; $display("FAIL reset_cmd: got %h expected 0", ref_cmd); end
        checks++; if (ref_ch !== 1'b0) begin errors++; $display("FAIL reset_ch: got %b expected 0", ref_ch); end
        checks++; if (ref_urgent !== 1'b0) begin errors++; $display("FAIL reset_urgent: got %b expected 0", ref_urgent); end
        checks++; if (debt_ovf !== 2'b00) begin errors++; $display("FAIL reset_ovf: got %b expected 00", debt_ovf); end
        rst_n = 1'b1;
        step(1);
    endtask

    task automatic test_first_tick();
        int lat;
        do_reset();
        load(1'b0, 1'b1, 4'hA, 16'd1);
        ref_ready = 1'b1;
        start();
        measure_latency(lat);
        checks++; if (lat !== 131) begin errors++; $display("FAIL first_latency: got %0d expected 131", lat); end
        checks++; if (ref_cmd !== 19'h14000) begin errors++; $display("FAIL first_cmd: got %h expected 14000", ref_cmd); end
        checks++; if (ref_ch !== 1'b0) begin errors++; $display("FAIL first_ch: got %b expected 0", ref_ch); end
        checks++; if (ref_urgent !== 1'b0) begin errors++; $display("FAIL first_urgent: got %b expected 0", ref_urgent); end
    endtask

    task automatic test_rr_drain();
        int cnt, gaps;
        logic [7:0] seq;
        logic [18:0] cmd1;
        do_reset();
        load(1'b0, 1'b1, 4'hA, 16'd1);
        load(1'b1, 1'b1, 4'h5, 16'd1);
        start();
        step_to(390);
        checks++; if (ref_valid !== 1'b1) begin errors++; $display("FAIL rr_held_valid: got %b expected 1", ref_valid); end
        checks++; if (ref_ch !== 1'b0) begin errors++; $display("FAIL rr_held_ch: got %b expected 0", ref_ch); end
        ref_ready = 1'b1;
        run_grants(40, cnt, gaps, seq, cmd1);
        ref_ready = 1'b0;
        checks++; if (cnt !== 6) begin errors++; $display("FAIL rr_count: got %0d expected 6", cnt); end
        checks++; if (seq !== 8'b0010_1010) begin errors++; $display("FAIL rr_order: got %b expected 00101010", seq); end
        checks++; if (gaps !== 0) begin errors++; $display("FAIL rr_gap: got %0d back-to-back expected 0", gaps); end
        checks++; if (cmd1 !== 19'h0A000) begin errors++; $display("FAIL rr_cmd_ch1: got %h expected 0a000", cmd1); end
    endtask

    task automatic test_saturation();
        int cnt, gaps;
        logic [7:0] seq;
        logic [18:0] cmd1;
        do_reset();
        load(1'b0, 1'b1, 4'h3, 16'd1);
        start();
        step_to(1100);
        checks++; if (debt_ovf !== 2'b00) begin errors++; $display("FAIL sat_ovf_early: got %b expected 00", debt_ovf); end
        step_to(1160);
        checks++; if (debt_ovf !== 2'b01) begin errors++; $display("FAIL sat_ovf_set: got %b expected 01", debt_ovf); end
        step_to(1290);
        ref_ready = 1'b1;
        run_grants(60, cnt, gaps, seq, cmd1);
        ref_ready = 1'b0;
        checks++; if (cnt !== 8) begin errors++; $display("FAIL sat_count: got %0d expected 8", cnt); end
        checks++; if (gaps !== 0) begin errors++; $display("FAIL sat_gap: got %0d back-to-back expected 0", gaps); end
        checks++; if (debt_ovf !== 2'b01) begin errors++; $display("FAIL sat_ovf_sticky: got %b expected 01", debt_ovf); end
    endtask

    task automatic test_urgent();
        do_reset();
        load(1'b0, 1'b1, 4'h1, 16'd2);
        load(1'b1, 1'b1, 4'h2, 16'd1);
        start();
        step_to(1281);
        checks++; if (ref_ch !== 1'b1 || ref_valid !== 1'b1) begin errors++; $display("FAIL urg_pre: got valid=%b ch=%b expected valid=1 ch=1", ref_valid, ref_ch); end
        ref_ready = 1'b1;
        step(1);
        ref_ready = 1'b0;
        checks++; if (ref_valid !== 1'b0) begin errors++; $display("FAIL urg_gap: got %b expected 0", ref_valid); end
        step(1);
        checks++; if (ref_valid !== 1'b1) begin errors++; $display("FAIL urg_valid: got %b expected 1", ref_valid); end
        checks++; if (ref_ch !== EXP_URG) begin errors++; $display("FAIL urg_ch: got %b expected %b", ref_ch, EXP_URG); end
        checks++; if (ref_urgent !== EXP_URG) begin errors++; $display("FAIL urg_flag: got %b expected %b", ref_urgent, EXP_URG); end
        checks++; if (ref_cmd !== (EXP_URG ? 19'h04000 : 19'h02000)) begin errors++; $display("FAIL urg_cmd: got %h expected %h", ref_cmd, EXP_URG ? 19'h04000 : 19'h02000); end
        checks++; if (debt_ovf !== 2'b10) begin errors++; $display("FAIL urg_ovf: got %b expected 10", debt_ovf); end
    endtask

    task automatic test_disable();
        int cnt, gaps;
        logic [7:0] seq;
        logic [18:0] cmd1;
        do_reset();
        load(1'b0, 1'b1, 4'h6, 16'd1);
        start();
        step_to(300);
        load(1'b0, 1'b0, 4'h6, 16'd1);
        step_to(390);
        ref_ready = 1'b1;
        run_grants(310, cnt, gaps, seq, cmd1);
        ref_ready = 1'b0;
        checks++; if (cnt !== 3) begin errors++; $display("FAIL dis_count: got %0d expected 3", cnt); end
        checks++; if (debt_ovf !== 2'b00) begin errors++; $display("FAIL dis_ovf: got %b expected 00", debt_ovf); end
    endtask

    task automatic test_async_reset();
        int cnt, gaps, lat;
        logic [7:0] seq;
        logic [18:0] cmd1;
        do_reset();
        load(1'b0, 1'b1, 4'h9, 16'd1);
        start();
        step_to(135);
        checks++; if (ref_valid !== 1'b1) begin errors++; $display("FAIL ar_pre_valid: got %b expected 1", ref_valid); end
        #3 rst_n = 1'b0;
        #1;
        checks++; if (ref_valid !== 1'b0) begin errors++; $display("FAIL ar_valid: got %b expected 0", ref_valid); end
        checks++; if (ref_cmd !== 19'h0) begin errors++; $display("FAIL ar_cmd: got %h expected 0", ref_cmd); end
        checks++; if (ref_ch !== 1'b0) begin errors++; $display("FAIL ar_ch: got %b expected 0", ref_ch); end
        step(2);
        rst_n = 1'b1;
        ref_ready = 1'b1;
        run_grants(300, cnt, gaps, seq, cmd1);
        checks++; if (cnt !== 0) begin errors++; $display("FAIL ar_no_init: got %0d grants expected 0", cnt); end
        load(1'b0, 1'b1, 4'h9, 16'd1);
        start();
        measure_latency(lat);
        checks++; if (lat !== 131) begin errors++; $display("FAIL ar_relatency: got %0d expected 131", lat); end
        checks++; if (ref_cmd !== 19'h12000) begin errors++; $display("FAIL ar_cmd_after: got %h expected 12000", ref_cmd); end
        ref_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_first_tick();
        test_rr_drain();
        test_saturation();
        test_urgent();
        test_disable();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
